// File: rtl/act_quant_packer.sv
// Requantizes accumulator results to DATA_WIDTH, packs PACK lanes per word and
// streams the words through a small FIFO to the activation buffer write port.
module act_quant_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIAS_WIDTH = 32,
    parameter int SHIFT      = 8,
    parameter int PACK       = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst,
    input  logic                         layer,
    input  logic signed [BIAS_WIDTH-1:0] sum,
    input  logic                         sum_valid,
    output logic                         sum_ready,
    input  logic                         flush,
    input  logic                         addr_clr,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [DATA_WIDTH*PACK-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic                         done_o
);
    localparam int WW = DATA_WIDTH * PACK;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] C_LANE_LAST = LW'(PACK - 1);
    localparam logic [PW-1:0] C_PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] C_RDY_MAX   = CW'(FIFO_DEPTH - 2);
    localparam logic signed [BIAS_WIDTH:0] C_HALF = {{BIAS_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [BIAS_WIDTH:0] C_UMAX = {{(BIAS_WIDTH+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    localparam logic signed [BIAS_WIDTH:0] C_SMAX = {{(BIAS_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [BIAS_WIDTH:0] C_SMIN = {{(BIAS_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_DRAIN = 2'd2} state_t;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [BIAS_WIDTH-1:0] s,
                                                      input logic fc);
        logic signed [BIAS_WIDTH:0] t;
        logic signed [BIAS_WIDTH:0] q;
        t = $signed({s[BIAS_WIDTH-1], s}) + C_HALF;
        q = t >>> SHIFT;
        if (!fc) begin
            if (q[BIAS_WIDTH])   return {DATA_WIDTH{1'b0}};
            else if (q > C_UMAX) return {DATA_WIDTH{1'b1}};
            else                 return q[DATA_WIDTH-1:0];
        end else begin
            if (q < C_SMIN)      return C_SMIN[DATA_WIDTH-1:0];
            else if (q > C_SMAX) return C_SMAX[DATA_WIDTH-1:0];
            else                 return q[DATA_WIDTH-1:0];
        end
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == C_PTR_LAST) return {PW{1'b0}};
        else                 return p + PW'(1);
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_live;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_q_valid;
    logic [DATA_WIDTH-1:0] r_q_data;
    logic [LW-1:0]         r_lane;
    logic [WW-1:0]         r_pack;
    logic [WW-1:0]         w_pack_word;
    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_accept;
    logic                  w_q_push;
    logic                  w_flush_push;
    logic                  w_push;
    logic                  w_pop;
    logic [WW-1:0]         w_push_data;
    logic                  w_addr_clr;

    assign sum_ready    = r_live && (r_state == ST_RUN) && (r_count <= C_RDY_MAX);
    assign w_accept     = sum_valid && sum_ready;
    assign wr_valid     = (r_count != {CW{1'b0}});
    assign wr_data      = r_mem[r_rd_ptr];
    assign wr_addr      = r_addr;
    assign done_o       = r_done;
    assign w_pop        = wr_valid && wr_ready;
    assign w_q_push     = r_q_valid && (r_lane == C_LANE_LAST);
    assign w_push       = w_q_push || w_flush_push;
    assign w_push_data  = w_q_push ? w_pack_word : r_pack;
    assign w_addr_clr   = addr_clr && (r_state == ST_RUN) && !r_q_valid && !wr_valid;

    // Merge the quantized value into its lane of the current word.
    always_comb begin
        w_pack_word = r_pack;
        w_pack_word[r_lane*DATA_WIDTH +: DATA_WIDTH] = r_q_data;
    end

    // Flush sequencing: wait for stage Q, close the partial word, then drain.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_flush_push = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) w_state_nxt = ST_FLUSH;
                else       w_state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                if (!r_q_valid) begin
                    w_state_nxt  = ST_DRAIN;
                    w_flush_push = (r_lane != {LW{1'b0}});
                end else begin
                    w_state_nxt  = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (!wr_valid) begin
                    w_state_nxt = ST_RUN;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Control state, done pulse and the quantize stage.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_live    <= 1'b0;
            r_state   <= ST_RUN;
            r_done    <= 1'b0;
            r_q_valid <= 1'b0;
            r_q_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_live    <= 1'b1;
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_q_valid <= w_accept;
            if (w_accept) r_q_data <= requant(sum, layer);
            else          r_q_data <= r_q_data;
        end
    end

    // Lane counter and pack register.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_lane <= {LW{1'b0}};
            r_pack <= {WW{1'b0}};
        end else if (w_push) begin
            r_lane <= {LW{1'b0}};
            r_pack <= {WW{1'b0}};
        end else if (r_q_valid) begin
            r_lane <= r_lane + LW'(1);
            r_pack <= w_pack_word;
        end else begin
            r_lane <= r_lane;
            r_pack <= r_pack;
        end
    end

    // Output word FIFO; head entry drives the write port directly.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= {WW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            else       r_rd_ptr <= r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write address advances per accepted write and wraps naturally.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            r_addr <= {ADDR_WIDTH{1'b0}};
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end else if (w_addr_clr) begin
            r_addr <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_addr <= r_addr;
        end
    end

endmodule
